// File: rtl/load_store_unit.sv
// Load/store unit between the core MEM stage and word-only data memory.
// Sub-word stores use read-modify-write. Loads are extracted and sign- or zero-extended.
module load_store_unit #(
  parameter logic [23:0] ADDR_HI   = 24'h660000,
  parameter logic [31:0] ERR_RDATA = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        done_o,
  output logic        err_o,
  output logic        stall_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rd_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q;
  logic [31:0] addr_q, wd_q, word_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic        legal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] merged;

  always_comb begin
    legal = (addr_i[31:8] == ADDR_HI);
    case (size_i)
      3'b000: ;
      3'b001: if (addr_i[0]) legal = 1'b0;
      3'b010: if (addr_i[1:0] != 2'b00) legal = 1'b0;
      3'b100: if (we_i) legal = 1'b0;
      3'b101: if (we_i || addr_i[0]) legal = 1'b0;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte = mem_rd_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = mem_rd_i;
    endcase
  end

  // Only the addressed lane of the previously read word is replaced.
  always_comb begin
    merged = word_q;
    case (size_q[1:0])
      2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wd_q[15:0];
        else           merged[15:0]  = wd_q[15:0];
      end
      default: merged = wd_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      size_q  <= 3'b000;
      we_q    <= 1'b0;
      word_q  <= 32'h0;
      rd_o    <= 32'h0;
      err_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q <= addr_i;
            wd_q   <= wd_i;
            size_q <= size_i;
            we_q   <= we_i;
            if (!legal) begin
              state_q <= DONE;
              err_o   <= 1'b1;
              rd_o    <= ERR_RDATA;
            end else if (we_i && size_i == 3'b010) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          word_q <= mem_rd_i;
          if (we_q) begin
            state_q <= WR;
          end else begin
            rd_o    <= ld_val;
            state_q <= DONE;
          end
        end
        WR: begin
          rd_o    <= ERR_RDATA;
          state_q <= DONE;
        end
        default: begin
          err_o   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done_o     = (state_q == DONE);
  assign stall_o    = ((state_q == IDLE) && req_i) || (state_q == RD) || (state_q == WR);
  assign mem_we_o   = (state_q == WR);
  assign mem_addr_o = {addr_q[31:2], 2'b00};
  assign mem_wd_o   = merged;

endmodule
